// File: rtl/psd_accumulator.sv
// Two-channel integrate-and-dump decimator for the phase-sensitive demodulator.
// Sums DECIMATION signed I/Q products per sync-aligned window and presents each pair on valid/ready.
module psd_accumulator #(
    parameter int IN_WIDTH   = 8,
    parameter int DECIMATION = 1024,
    localparam int ACC_WIDTH = IN_WIDTH + $clog2(DECIMATION)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic                        i_sync,
    input  logic        [IN_WIDTH-1:0]  i_i,
    input  logic        [IN_WIDTH-1:0]  i_q,
    output logic signed [ACC_WIDTH-1:0] o_i,
    output logic signed [ACC_WIDTH-1:0] o_q,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_overrun,
    output logic                        o_busy
);

    localparam int CNT_WIDTH = $clog2(DECIMATION);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DECIMATION - 1);

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        ACCUM     = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic        [CNT_WIDTH-1:0] cnt;
    logic signed [ACC_WIDTH-1:0] acc_i;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] sample_i;
    logic signed [ACC_WIDTH-1:0] sample_q;
    logic signed [ACC_WIDTH-1:0] sum_i;
    logic signed [ACC_WIDTH-1:0] sum_q;
    logic                        last_sample;
    logic                        transfer;

    assign sample_i    = {{(ACC_WIDTH - IN_WIDTH){i_i[IN_WIDTH-1]}}, i_i};
    assign sample_q    = {{(ACC_WIDTH - IN_WIDTH){i_q[IN_WIDTH-1]}}, i_q};
    assign sum_i       = acc_i + sample_i;
    assign sum_q       = acc_q + sample_q;
    assign last_sample = (cnt == LAST_CNT);
    assign transfer    = o_valid && i_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        if (state == WAIT_SYNC && i_en && i_sync) begin
            state_next = ACCUM;
        end
    end

    always_comb begin
        o_busy = (state == ACCUM);
    end

    // Once synced the window rolls over forever; only reset returns to WAIT_SYNC.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt       <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
            o_i       <= '0;
            o_q       <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            if (transfer) begin
                o_valid <= 1'b0;
            end
            if (i_en) begin
                case (state)
                    WAIT_SYNC: begin
                        if (i_sync) begin
                            acc_i <= sample_i;
                            acc_q <= sample_q;
                            cnt   <= CNT_WIDTH'(1);
                        end
                    end
                    ACCUM: begin
                        if (last_sample) begin
                            o_i     <= sum_i;
                            o_q     <= sum_q;
                            o_valid <= 1'b1;
                            acc_i   <= '0;
                            acc_q   <= '0;
                            cnt     <= '0;
                            if (o_valid && !i_ready) begin
                                o_overrun <= 1'b1;
                            end
                        end else begin
                            acc_i <= sum_i;
                            acc_q <= sum_q;
                            cnt   <= cnt + CNT_WIDTH'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
